fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory's `pc` input. Pairs the memory's one-cycle-late registered instruction with the address that produced it, and presents a valid/pc/instruction bundle to decode. Handles decode back-pressure (stall) and control-flow redirects from execute (taken branch, jump) by inserting bubbles.

---
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs the registered imem word with its
// address, and presents a valid/pc/inst bundle to decode with stall hold and redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_q1_q;
  logic        v_q1_q;
  logic        h_act_q;
  logic        h_valid_q;
  logic [31:0] h_pc_q;
  logic [31:0] h_inst_q;

  logic [31:0] live_inst;
  logic        sel_valid;
  logic [31:0] sel_pc;
  logic [31:0] sel_inst;
  logic        hold_capture;
  logic [1:0]  unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  // NOTE: combinational blocks assign a default first so no path leaves pc_d unassigned (no latch).
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
    else if (stall)     pc_d = pc_q;
  end

  // Capture only on the first stalled cycle; later stall cycles keep the original bundle.
  assign hold_capture = stall && !h_act_q && !redirect_valid;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pc_q1_q   <= RESET_PC;
      v_q1_q    <= 1'b0;
      h_act_q   <= 1'b0;
      h_valid_q <= 1'b0;
      h_pc_q    <= RESET_PC;
      h_inst_q  <= NOP_INST;
    end else begin
      pc_q    <= pc_d;
      pc_q1_q <= pc_q;
      v_q1_q  <= !redirect_valid;
      h_act_q <= stall && !redirect_valid;
      if (hold_capture) begin
        h_valid_q <= v_q1_q;
        h_pc_q    <= pc_q1_q;
        h_inst_q  <= live_inst;
      end
    end
  end

  assign imem_pc   = pc_q;
  assign live_inst = v_q1_q ? imem_inst : NOP_INST;

  assign sel_valid = h_act_q ? h_valid_q : v_q1_q;
  assign sel_pc    = h_act_q ? h_pc_q    : pc_q1_q;
  assign sel_inst  = h_act_q ? h_inst_q  : live_inst;

  // A redirect in this cycle squashes whatever younger instruction is on display.
  assign id_valid = sel_valid && !redirect_valid;
  assign id_inst  = redirect_valid ? NOP_INST : sel_inst;
  assign id_pc    = sel_pc;
  assign id_pc4   = sel_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with spec-derived tables,
// then randomized stall/redirect traffic compared against a decode-view reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_pc4(id_pc4)
  );

  // Memory content: word k holds 0x100 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  always @(posedge clk) imem_inst <= mem_word(imem_pc);

  // Reference model in decode terms: the item on display, and the address decode sees next.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pc    <= RST_PC;
      m_next  <= RST_PC;
    end else if (redirect_valid) begin
      m_valid <= 1'b0;
      m_next  <= redirect_pc & 32'hFFFF_FFFC;
    end else if (!stall) begin
      m_valid <= 1'b1;
      m_pc    <= m_next;
      m_next  <= m_next + 32'd4;
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    stall = s; redirect_valid = r; redirect_pc = t;
    #1;
  endtask

  // Leaves the bench in cycle 0 after reset release, inputs idle.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    checks++;
    if (id_valid !== 1'b0 || id_pc !== RST_PC || id_inst !== NOP || id_pc4 !== RST_PC + 32'd4 || imem_pc !== RST_PC) begin
      errors++;
      $display("FAIL reset_values: valid=%b pc=%h inst=%h pc4=%h imem_pc=%h, want 0/%h/%h/%h/%h",
               id_valid, id_pc, id_inst, id_pc4, imem_pc, RST_PC, NOP, RST_PC + 32'd4, RST_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_pc !== RST_PC) begin
      errors++;
      $display("FAIL reset_cycle0: valid=%b imem_pc=%h, want 0/%h", id_valid, imem_pc, RST_PC);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== 32'(32'h100 + k) || id_pc4 !== 32'(4 * k + 4)) begin
        errors++;
        $display("FAIL stream_c%0d: valid=%b pc=%h inst=%h pc4=%h, want 1/%h/%h/%h",
                 k + 1, id_valid, id_pc, id_inst, id_pc4, 4 * k, 32'h100 + k, 4 * k + 4);
      end
    end
  endtask

  task automatic test_single_stall();
    logic        st [6] = '{0, 0, 1, 0, 0, 0};
    logic [31:0] ep [6] = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12, 32'd16};
    logic [31:0] ei [6] = '{32'd4, 32'd8, 32'd12, 32'd12, 32'd16, 32'd20};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(st[i], 1'b0, 32'h0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== ep[i] || id_inst !== mem_word(ep[i]) || id_pc4 !== ep[i] + 32'd4 || imem_pc !== ei[i]) begin
        errors++;
        $display("FAIL single_stall_c%0d: valid=%b pc=%h inst=%h imem_pc=%h, want 1/%h/%h/%h",
                 i + 1, id_valid, id_pc, id_inst, imem_pc, ep[i], mem_word(ep[i]), ei[i]);
      end
    end
  endtask

  task automatic test_long_stall();
    logic        st [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] ep [10] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12, 32'd12, 32'd16, 32'd20};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(st[i], 1'b0, 32'h0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== ep[i] || id_inst !== mem_word(ep[i]) || imem_pc !== ep[i] + 32'd4) begin
        errors++;
        $display("FAIL long_stall_c%0d: valid=%b pc=%h inst=%h imem_pc=%h, want 1/%h/%h/%h",
                 i + 1, id_valid, id_pc, id_inst, imem_pc, ep[i], mem_word(ep[i]), ep[i] + 32'd4);
      end
    end
  endtask

  task automatic test_redirect();
    logic        rd [6] = '{0, 0, 1, 0, 0, 0};
    logic        ev [6] = '{1, 1, 0, 0, 1, 1};
    logic [31:0] ep [6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h40, 32'h44};
    logic [31:0] ei [6] = '{32'h4, 32'h8, 32'hC, 32'h40, 32'h44, 32'h48};
    logic [31:0] tg;
    logic [31:0] exp_inst;
    for (int k = 0; k < 2; k++) begin
      tg = (k == 0) ? 32'h40 : 32'h43;
      do_reset();
      for (int i = 0; i < 6; i++) begin
        cyc(1'b0, rd[i], tg);
        exp_inst = ev[i] ? mem_word(ep[i]) : NOP;
        checks++;
        if (id_valid !== ev[i] || id_inst !== exp_inst || imem_pc !== ei[i] || (ev[i] && (id_pc !== ep[i] || id_pc4 !== ep[i] + 32'd4))) begin
          errors++;
          $display("FAIL redirect_%h_c%0d: valid=%b pc=%h inst=%h imem_pc=%h, want %b/%h/%h/%h",
                   tg, i + 1, id_valid, id_pc, id_inst, imem_pc, ev[i], ep[i], exp_inst, ei[i]);
        end
      end
    end
  endtask

  task automatic test_redirect_stall();
    logic        st [7] = '{0, 0, 1, 1, 0, 0, 0};
    logic        rd [7] = '{0, 0, 0, 1, 0, 0, 0};
    logic        ev [7] = '{1, 1, 1, 0, 0, 1, 1};
    logic [31:0] ep [7] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h0, 32'h40, 32'h44};
    logic [31:0] ei [7] = '{32'h4, 32'h8, 32'hC, 32'hC, 32'h40, 32'h44, 32'h48};
    logic [31:0] exp_inst;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(st[i], rd[i], 32'h40);
      exp_inst = ev[i] ? mem_word(ep[i]) : NOP;
      checks++;
      if (id_valid !== ev[i] || id_inst !== exp_inst || imem_pc !== ei[i] || (ev[i] && id_pc !== ep[i])) begin
        errors++;
        $display("FAIL redirect_stall_c%0d: valid=%b pc=%h inst=%h imem_pc=%h, want %b/%h/%h/%h",
                 i + 1, id_valid, id_pc, id_inst, imem_pc, ev[i], ep[i], exp_inst, ei[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic        rd [5] = '{1, 0, 0, 0, 0};
    logic        ev [5] = '{0, 0, 1, 1, 1};
    logic [31:0] ep [5] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    logic [31:0] ei [5] = '{32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    logic [31:0] exp_inst;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, rd[i], 32'hFFFF_FFF8);
      exp_inst = ev[i] ? mem_word(ep[i]) : NOP;
      checks++;
      if (id_valid !== ev[i] || id_inst !== exp_inst || imem_pc !== ei[i] || (ev[i] && (id_pc !== ep[i] || id_pc4 !== ep[i] + 32'd4))) begin
        errors++;
        $display("FAIL wrap_c%0d: valid=%b pc=%h inst=%h pc4=%h imem_pc=%h, want %b/%h/%h/%h",
                 i + 1, id_valid, id_pc, id_inst, id_pc4, imem_pc, ev[i], ep[i], exp_inst, ei[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_pc !== RST_PC || id_inst !== NOP || id_pc !== RST_PC) begin
      errors++;
      $display("FAIL async_reset: valid=%b imem_pc=%h inst=%h pc=%h, want 0/%h/%h/%h",
               id_valid, imem_pc, id_inst, id_pc, RST_PC, NOP, RST_PC);
    end
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_pc !== RST_PC) begin
      errors++;
      $display("FAIL async_restart_c0: valid=%b imem_pc=%h, want 0/%h", id_valid, imem_pc, RST_PC);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== 32'(32'h100 + k)) begin
        errors++;
        $display("FAIL async_restart_c%0d: valid=%b pc=%h inst=%h, want 1/%h/%h",
                 k + 1, id_valid, id_pc, id_inst, 4 * k, 32'h100 + k);
      end
    end
  endtask

  task automatic test_random();
    logic        s, r;
    logic [31:0] t;
    logic        exp_valid;
    logic [31:0] exp_inst;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 10);
      t = $urandom();
      cyc(s, r, t);
      exp_valid = m_valid && !r;
      exp_inst  = exp_valid ? mem_word(m_pc) : NOP;
      checks++;
      if (id_valid !== exp_valid || id_inst !== exp_inst || imem_pc !== m_next ||
          (exp_valid && (id_pc !== m_pc || id_pc4 !== m_pc + 32'd4))) begin
        errors++;
        $display("FAIL random_c%0d: valid=%b pc=%h inst=%h pc4=%h imem_pc=%h, want %b/%h/%h/%h/%h",
                 i, id_valid, id_pc, id_inst, id_pc4, imem_pc, exp_valid, m_pc, exp_inst, m_pc + 32'd4, m_next);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_stall();
    test_long_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
